// File: rtl/x_uart_cmd.sv
`default_nettype none
// ============================================================================
// x_uart_cmd
// Decodes 1-/2-byte UART commands into register writes/reads and measurement
// triggers, returning one response byte per command over valid/ready.
// Revision: 1.0
// ============================================================================
module x_uart_cmd #(
    parameter int         p_timeout = 120000,
    parameter logic [7:0] p_ack     = 8'h06,
    parameter logic [7:0] p_nak     = 8'h15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_reg_we,
    output logic       o_reg_re,
    output logic [3:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    input  logic [7:0] i_reg_rdata,
    output logic       o_trig,
    input  logic       i_done,
    input  logic [7:0] i_result,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_err
);

    localparam int              c_tw   = (p_timeout > 1) ? $clog2(p_timeout) : 1;
    localparam logic [c_tw-1:0] c_tmax = c_tw'(p_timeout - 1);

    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_op_read  = 2'b10;
    localparam logic [1:0] c_op_trig  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_TRIG  = 3'd4,
        S_WAIT  = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t          r_state;
    logic [c_tw-1:0] r_timer;
    logic [3:0]      r_addr;
    logic [7:0]      r_wdata;
    logic [7:0]      r_resp;
    logic            r_reg_we;
    logic            r_reg_re;
    logic            r_trig;
    logic            r_tx_valid;
    logic            r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_reg_we   <= 1'b0;
            r_reg_re   <= 1'b0;
            r_trig     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Strobes are single-cycle; the timer only runs while it is explicitly advanced.
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            r_trig   <= 1'b0;
            r_err    <= 1'b0;
            r_timer  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data[7:6])
                            c_op_write: begin
                                r_addr  <= i_rx_data[3:0];
                                r_state <= S_DATA;
                            end
                            c_op_read: begin
                                r_addr   <= i_rx_data[3:0];
                                r_reg_re <= 1'b1;
                                r_state  <= S_READ;
                            end
                            c_op_trig: begin
                                r_trig  <= 1'b1;
                                r_state <= S_TRIG;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DATA: begin
                    // A byte on the final timer cycle still completes the write.
                    if (i_rx_valid) begin
                        r_wdata  <= i_rx_data;
                        r_reg_we <= 1'b1;
                        r_state  <= S_WRITE;
                    end else if (r_timer == c_tmax) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_err      <= i_rx_valid;
                    r_resp     <= p_ack;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_READ: begin
                    r_err      <= i_rx_valid;
                    r_resp     <= i_reg_rdata;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_TRIG: begin
                    r_err   <= i_rx_valid;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_err <= i_rx_valid;
                    if (i_done) begin
                        r_resp     <= i_result;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (r_timer == c_tmax) begin
                        r_resp     <= p_nak;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    r_err <= i_rx_valid;
                    if (r_tx_valid && i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_reg_addr  = r_addr;
    assign o_reg_wdata = r_wdata;
    assign o_trig      = r_trig;
    assign o_tx_valid  = r_tx_valid;
    assign o_tx_data   = r_resp;
    assign o_busy      = (r_state != S_IDLE);
    assign o_err       = r_err;

endmodule
`default_nettype wire
